// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with combinational hit path,
// compressed/straddling instruction support and byte-serial line refill.
module inst_cache #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] fetch_addr,
  output logic [31:0] inst,
  output logic        inst_length,
  output logic        inst_available,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata
);
  localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_BYTES = 1 << OFFSET_BITS;

  typedef enum logic {IDLE, REFILL} state_t;

  logic [7:0]            data_q [LINES*LINE_BYTES];
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [LINES-1:0]      valid_q, valid_d;
  state_t                state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic                  discard_q, discard_d;

  logic [31:0]           a_lo, a_hi;
  logic [INDEX_BITS-1:0] idx_lo, idx_hi, refill_idx;
  logic [OFFSET_BITS-2:0] hw_lo, hw_hi;
  logic [TAG_BITS-1:0]   tag_lo, tag_hi, refill_tag;
  logic [15:0]           lo, hi;
  logic                  hit_lo, hit_hi, is32, wr_en, last_byte;
  logic                  unused_bits;

  // hi halfword is looked up independently so a line-crossing fetch uses the next line
  assign a_lo   = {fetch_addr[31:1], 1'b0};
  assign a_hi   = a_lo + 32'd2;
  assign idx_lo = a_lo[OFFSET_BITS +: INDEX_BITS];
  assign idx_hi = a_hi[OFFSET_BITS +: INDEX_BITS];
  assign hw_lo  = a_lo[OFFSET_BITS-1:1];
  assign hw_hi  = a_hi[OFFSET_BITS-1:1];
  assign tag_lo = a_lo[31 -: TAG_BITS];
  assign tag_hi = a_hi[31 -: TAG_BITS];
  assign unused_bits = ^{fetch_addr[0], a_lo[0], a_hi[0]};

  assign lo     = {data_q[{idx_lo, hw_lo, 1'b1}], data_q[{idx_lo, hw_lo, 1'b0}]};
  assign hi     = {data_q[{idx_hi, hw_hi, 1'b1}], data_q[{idx_hi, hw_hi, 1'b0}]};
  assign hit_lo = valid_q[idx_lo] && (tag_q[idx_lo] == tag_lo);
  assign hit_hi = valid_q[idx_hi] && (tag_q[idx_hi] == tag_hi);
  assign is32   = (lo[1:0] == 2'b11);

  assign inst           = is32 ? {hi, lo} : {16'h0000, lo};
  assign inst_length    = is32;
  assign inst_available = (state_q == IDLE) && hit_lo && (!is32 || hit_hi) && !flush;
  assign mem_req        = (state_q == REFILL);
  assign mem_addr       = mem_addr_q;

  assign refill_idx = mem_addr_q[OFFSET_BITS +: INDEX_BITS];
  assign refill_tag = mem_addr_q[31 -: TAG_BITS];
  assign last_byte  = &cnt_q;
  assign wr_en      = (state_q == REFILL) && rdy_in && mem_rvalid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    valid_d    = valid_q;
    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (flush) begin
            valid_d = '0;
          end else if (!hit_lo) begin
            mem_addr_d      = {a_lo[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            valid_d[idx_lo] = 1'b0;
            cnt_d           = '0;
            state_d         = REFILL;
          end else if (is32 && !hit_hi) begin
            mem_addr_d      = {a_hi[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            valid_d[idx_hi] = 1'b0;
            cnt_d           = '0;
            state_d         = REFILL;
          end
        end
        REFILL: begin
          // a flush mid-refill must also keep the in-flight line from going valid
          if (flush) begin
            valid_d   = '0;
            discard_d = 1'b1;
          end
          if (mem_rvalid) begin
            cnt_d = cnt_q + 1'b1;
            if (last_byte) begin
              state_d   = IDLE;
              discard_d = 1'b0;
              if (!discard_q && !flush) valid_d[refill_idx] = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      data_q[{refill_idx, cnt_q}] <= mem_rdata;
      if (last_byte) tag_q[refill_idx] <= refill_tag;
    end
  end
endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
Direct-mapped, read-only instruction cache. It is the responder to the fetch unit's PC-driven fetch interface. It returns the instruction at fetch_addr combinationally on a hit, including 16-bit compressed instructions and 32-bit instructions that straddle a line boundary. On a miss it refills one line from the byte-wide memory controller.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines)
OFFSET_BITS, 4, log2 of line size in bytes (16 B); minimum 2
TAG_BITS, 32-INDEX_BITS-OFFSET_BITS, tag width (derived; not overridable)

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; low freezes all state
fetch_addr  in  32  PC from fetch unit; bit 0 ignored
inst  out  32  instruction; upper 16 bits zero when 16-bit
inst_length  out  1  1 = 32-bit, 0 = 16-bit
inst_available  out  1  hit: inst/inst_length valid this cycle
flush  in  1  invalidate all lines
mem_req  out  1  refill request, held high for the whole refill
mem_addr  out  32  line base address of the refill (offset bits zero)
mem_rvalid  in  1  one refill byte on mem_rdata this cycle
mem_rdata  in  8  refill byte, delivered in ascending address order

Behaviour:
- Storage: valid[2^INDEX_BITS], tag[], data bytes[]; idx = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS].
- Lookup (combinational):
  - lo = halfword at A = {fetch_addr[31:1],1'b0}; hit_lo = valid & tag match for A.
  - lo[1:0]==2'b11 → 32-bit. hi = halfword at A+2, computed mod 2^32. hi comes from the next line when A's offset = LINE_BYTES-2; hit_hi is a separate tag/valid check on A+2.
  - inst_length = (lo[1:0]==2'b11).
  - inst = inst_length ? {hi,lo} : {16'h0,lo}.
  - inst_available = state==IDLE & hit_lo & (!inst_length | hit_hi) & !flush.
- FSM states: IDLE, REFILL.
  - IDLE & rdy_in & !flush & !hit_lo → mem_addr = line base of A; clear valid[idx]; cnt=0; mem_req=1; go to REFILL.
  - IDLE, hit_lo, 32-bit, !hit_hi → same action, using line base of A+2.
  - REFILL: each mem_rvalid writes mem_rdata to byte cnt of the line and increments cnt. On byte LINE_BYTES-1: write tag, set valid (unless discard), mem_req=0, go to IDLE.
- Latency: hit = 0 cycles. Miss → mem_req rises the edge after detection; inst_available rises the cycle after the last byte. Straddling miss on both lines → two sequential refills, lo line first.
- Partial lines never hit (valid cleared at refill start).
- flush in IDLE: all valid cleared at the next edge. flush in REFILL: all valid cleared and discard set; the refill runs to completion without setting valid; discard cleared on return to IDLE.
- rdy_in low: no state, counter, valid or array update; mem_rvalid ignored (the controller must not deliver bytes then); outputs still reflect the current lookup.
- fetch_addr changing during REFILL: refill completes for the original line, then lookup is re-evaluated in IDLE.
- Reset (async, any time including mid-refill): valid all 0, state IDLE, mem_req 0, mem_addr 0, cnt 0, discard 0 → inst_available 0. Data/tag arrays are not reset.
- Wrap: A=0xFFFFFFFE with a 32-bit lo takes hi from address 0x00000000 (index 0).

Test Plan:
1. Reset, fetch_addr=0x0 → inst_available=0; next edge mem_req=1, mem_addr=0x0; feed bytes 13,05,A0,00,... (16 bytes) → cycle after the last byte: inst_available=1, inst=0x00A00513, inst_length=1, mem_req=0.
2. Same line, fetch_addr=0x4, bytes 01,45 → hit same cycle, inst=0x00004501, inst_length=0, no mem_req.
3. Straddle: line 0x0 cached, halfword at 0xE = 0x0513, line 0x10 absent → mem_req with mem_addr=0x10. After 16 bytes with 0x10..0x11 = A0,00 → inst=0x00A00513, inst_length=1.
4. Conflict: fill 0x000, then fetch 0x100 (same idx, INDEX_BITS=4) → refill at 0x100; a return to 0x000 misses again.
5. flush asserted at byte 5 of a refill → refill completes, line stays invalid, inst_available=0, new mem_req for the same line next cycle.
6. rdy_in low for 3 cycles mid-refill with mem_rvalid pulsing → cnt unchanged, no bytes written; resumes correctly. rst_in low mid-refill → mem_req=0 immediately, inst_available=0.
